// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle execute sequencer for the 16-bit datapath ALU.
// Takes one instruction word per 4 cycles (IDLE -> READ -> EXEC -> WB).
// The instruction is decoded into the ALU opcode and operands. Operands are read
// from the register file, and the result is written back. The 5-bit PSR is
// built from the ALU flags.
// Ports:
//   clk, rst_n                    clock / async active-low reset
//   inst, inst_valid, inst_ready  instruction handshake
//   rf_raddr_a/b, rf_rdata_a/b    register file reads (1-cycle latency)
//   rf_we, rf_waddr, rf_wdata     register file write-back
//   alu_a/b, alu_opcode, alu_carry_in, alu_c, alu_flags   ALU interface
//   psr                           processor status {Z,C,F,L,N}
//   done, err                     retire pulse / illegal-opcode pulse
module alu_sequencer #(
   parameter int DATA_W = 16,
   parameter int RA_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       inst,
   input  logic              inst_valid,
   output logic              inst_ready,
   output logic [RA_W-1:0]   rf_raddr_a,
   output logic [RA_W-1:0]   rf_raddr_b,
   input  logic [DATA_W-1:0] rf_rdata_a,
   input  logic [DATA_W-1:0] rf_rdata_b,
   output logic              rf_we,
   output logic [RA_W-1:0]   rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [7:0]        alu_opcode,
   output logic              alu_carry_in,
   input  logic [DATA_W-1:0] alu_c,
   input  logic [4:0]        alu_flags,
   output logic [4:0]        psr,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t            state_q, state_d;
   logic [15:0]       inst_q;
   logic [DATA_W-1:0] res_q;
   logic [4:0]        flags_q;
   logic [4:0]        psr_q;
   logic [DATA_W-1:0] alu_a_q, alu_b_q;
   logic [7:0]        alu_op_q;

   logic [7:0]        op_raw, op_dec;
   logic              legal, wr_en, psr_upd;
   logic [DATA_W-1:0] b_mux;

   // Only the hi=0 and hi=8 groups use the ext nibble as a sub-opcode.
   assign op_raw = (inst_q[15:12] == 4'h0 || inst_q[15:12] == 4'h8) ?
                   inst_q[15:8] & 8'hF0 | {4'h0, inst_q[7:4]} :
                   {inst_q[15:12], 4'h0};

   always_comb begin
      legal = 1'b0;
      case (op_raw)
         8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
         8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F,
         8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70,
         8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87,
         8'h90, 8'hB0: legal = 1'b1;
         default:      legal = 1'b0;
      endcase
   end

   assign op_dec = legal ? op_raw : 8'h00;

   always_comb begin
      b_mux = '0;
      if (legal) begin
         case (op_raw)
            8'h50, 8'h70, 8'h90, 8'hB0:
               b_mux = {{(DATA_W-8){inst_q[7]}}, inst_q[7:0]};
            8'h10, 8'h20, 8'h30, 8'h40, 8'h60:
               b_mux = {{(DATA_W-8){1'b0}}, inst_q[7:0]};
            8'h0C, 8'h80, 8'h81, 8'h82, 8'h83:
               b_mux = {{(DATA_W-4){1'b0}}, inst_q[3:0]};
            default:
               b_mux = rf_rdata_b;
         endcase
      end
   end

   // The CMP family and NOP only affect flags (or nothing). Shifts leave the PSR alone.
   assign wr_en   = legal && !(op_raw inside {8'h00, 8'h08, 8'h0B, 8'h0C, 8'hB0});
   assign psr_upd = legal && (op_raw != 8'h00) && (op_raw[7:3] != 5'b10000);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (inst_valid) state_d = READ;
         READ:    state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         inst_q   <= '0;
         res_q    <= '0;
         flags_q  <= '0;
         psr_q    <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && inst_valid) inst_q <= inst;
         if (state_q == EXEC) begin
            res_q    <= alu_c;
            flags_q  <= alu_flags;
            alu_a_q  <= rf_rdata_a;
            alu_b_q  <= b_mux;
            alu_op_q <= op_dec;
         end
         if (state_q == WB && psr_upd) psr_q <= flags_q;
      end
   end

   // The register file data arrives during EXEC. The ALU sees it live and then
   // holds it, so the operands stay stable outside EXEC.
   assign alu_a        = (state_q == EXEC) ? rf_rdata_a : alu_a_q;
   assign alu_b        = (state_q == EXEC) ? b_mux      : alu_b_q;
   assign alu_opcode   = (state_q == EXEC) ? op_dec     : alu_op_q;
   assign alu_carry_in = psr_q[3];

   assign inst_ready = (state_q == IDLE);
   assign rf_raddr_a = inst_q[11:8];
   assign rf_raddr_b = inst_q[3:0];
   assign rf_we      = (state_q == WB) && wr_en;
   assign rf_waddr   = inst_q[11:8];
   assign rf_wdata   = res_q;
   assign done       = (state_q == WB);
   assign err        = (state_q == WB) && !legal;
   assign psr        = psr_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
   logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
   logic        rf_we;
   logic [15:0] alu_a, alu_b, alu_c;
   logic [7:0]  alu_opcode;
   logic        alu_carry_in;
   logic [4:0]  alu_flags, psr;
   logic        done, err;

   always #5 clk = ~clk;

   alu_sequencer #(.DATA_W(16), .RA_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_a(alu_a), .alu_b(alu_b),
      .alu_opcode(alu_opcode), .alu_carry_in(alu_carry_in), .alu_c(alu_c),
      .alu_flags(alu_flags), .psr(psr), .done(done), .err(err)
   );

   // Register file: synchronous read, plus a preload port owned by the bench.
   logic [15:0] mem [16];
   logic        pl_we;
   logic [3:0]  pl_addr;
   logic [15:0] pl_data;

   always @(posedge clk) begin
      rf_rdata_a <= mem[rf_raddr_a];
      rf_rdata_b <= mem[rf_raddr_b];
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (rf_we) mem[rf_waddr] <= rf_wdata;
   end

   // Minimal ALU stand-in. Shifts and unknown opcodes return noisy flags, so
   // a PSR that is updated when it should not be changes visibly.
   always_comb begin
      logic [16:0] s;
      s = '0;
      alu_c = 16'hDEAD;
      alu_flags = 5'b11111;
      case (alu_opcode)
         8'h05, 8'h06, 8'h50, 8'h07: begin
            s = {1'b0, alu_a} + {1'b0, alu_b} + ((alu_opcode == 8'h07) ? {16'h0, alu_carry_in} : 17'h0);
            alu_c = s[15:0];
            alu_flags = {s[15:0] == 16'h0, s[16], 3'b000};
         end
         8'h09: begin
            alu_c = alu_a - alu_b;
            alu_flags = {alu_a == alu_b, alu_a < alu_b, 3'b000};
         end
         8'h0B: begin
            alu_c = 16'h0;
            alu_flags = {alu_a == alu_b, 2'b00, alu_a > alu_b, $signed(alu_a) < $signed(alu_b)};
         end
         8'h80: begin
            alu_c = alu_a << alu_b[3:0];
            alu_flags = 5'b10101;
         end
         default: ;
      endcase
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Values observed during one instruction.
   logic [15:0] o_a, o_b, o_wdata;
   logic [7:0]  o_op;
   logic [3:0]  o_ra, o_rb, o_waddr;
   logic [4:0]  o_psr;
   logic        o_cin, o_done_x, o_done, o_err, o_we;
   int          o_waits;

   // Entered and left at a negedge while the FSM is in IDLE.
   task automatic preload(input logic [3:0] a, input logic [15:0] d);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1 pl_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic run(input logic [15:0] i, input bit hold, input logic [15:0] nxt);
      int w;
      w = 0;
      while (!inst_ready && w < 20) begin @(negedge clk); w++; end
      if (w >= 20) check("ready_timeout", 32'd0, 32'd1);
      o_waits = w;
      inst = i; inst_valid = 1'b1;
      @(posedge clk); #1 inst_valid = 1'b0;
      @(negedge clk);                                   // READ
      o_ra = rf_raddr_a; o_rb = rf_raddr_b;
      @(negedge clk);                                   // EXEC
      o_a = alu_a; o_b = alu_b; o_op = alu_opcode; o_cin = alu_carry_in; o_done_x = done;
      @(negedge clk);                                   // WB
      o_done = done; o_err = err; o_we = rf_we; o_waddr = rf_waddr; o_wdata = rf_wdata;
      if (hold) begin inst = nxt; inst_valid = 1'b1; end
      @(negedge clk);                                   // IDLE
      o_psr = psr;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; inst = '0; inst_valid = 1'b0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", inst_ready, 1);
      check("rst_psr", psr, 0);
      check("rst_we_done_err", {rf_we, done, err}, 0);
      check("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
      check("rst_addr", {rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ADDI R10, 0xFF: sign-extended immediate, 5 + (-1) = 4 with carry out
      preload(4'hA, 16'h0005);
      run(16'h5AFF, 1'b0, 16'h0);
      check("addi_raddr", {o_ra, o_rb}, 8'hAF);
      check("addi_op", o_op, 8'h50);
      check("addi_a", o_a, 16'h0005);
      check("addi_b", o_b, 16'hFFFF);
      check("addi_done_early", o_done_x, 0);
      check("addi_done", {o_done, o_err}, 2'b10);
      check("addi_wb", {o_we, o_waddr, o_wdata}, {1'b1, 4'hA, 16'h0004});
      check("addi_psr", o_psr, 5'b01000);
      check("addi_mem", mem[10], 16'h0004);

      // Reset asserted in the middle of EXEC
      preload(4'h3, 16'h1234);
      preload(4'h1, 16'h1234);
      inst = 16'h0391; inst_valid = 1'b1;
      @(posedge clk); #1 inst_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", inst_ready, 1);
      check("midrst_psr", psr, 0);
      check("midrst_we", rf_we, 0);
      @(negedge clk);
      check("midrst_hold", {inst_ready, done, rf_we}, 3'b100);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_mem", mem[3], 16'h1234);

      // SUB R3, R1: equal operands -> zero result and Z set
      run(16'h0391, 1'b0, 16'h0);
      check("sub_op", o_op, 8'h09);
      check("sub_b", o_b, 16'h1234);
      check("sub_wb", {o_we, o_waddr, o_wdata}, {1'b1, 4'h3, 16'h0000});
      check("sub_psr", o_psr, 5'b10000);

      // CMP R2, R3: flags only, no write
      preload(4'h2, 16'h8000);
      preload(4'h3, 16'h0001);
      run(16'h02B3, 1'b0, 16'h0);
      check("cmp_op", o_op, 8'h0B);
      check("cmp_we", {o_we, o_done}, 2'b01);
      check("cmp_psr", o_psr, 5'b00011);

      // ADDU 0xFFFF + 1 -> sets carry
      preload(4'h6, 16'hFFFF);
      preload(4'h7, 16'h0001);
      preload(4'h4, 16'h0000);
      preload(4'h5, 16'h0000);
      preload(4'h0, 16'h5555);
      preload(4'h1, 16'h0100);
      preload(4'h2, 16'h0023);
      run(16'h0667, 1'b0, 16'h0);
      check("addu_op", o_op, 8'h06);
      check("addu_psr", o_psr, 5'b11000);

      // ADDCU R4, R5 consumes the carry produced by the previous instruction
      run(16'h0475, 1'b0, 16'h0);
      check("addcu_op_cin", {o_op, o_cin}, {8'h07, 1'b1});
      check("addcu_wb", {o_we, o_waddr, o_wdata}, {1'b1, 4'h4, 16'h0001});
      check("addcu_psr", o_psr, 5'b00000);

      // LSHI R4, 3: 4-bit immediate, PSR untouched
      run(16'h8403, 1'b0, 16'h0);
      check("lshi_op", o_op, 8'h80);
      check("lshi_ab", {o_a, o_b}, {16'h0001, 16'h0003});
      check("lshi_wb", {o_we, o_waddr, o_wdata}, {1'b1, 4'h4, 16'h0008});
      check("lshi_psr", o_psr, 5'b00000);

      // Illegal opcode 0xC0, with the next instruction held valid during WB
      run(16'hC000, 1'b1, 16'h0152);
      check("ill_op", o_op, 8'h00);
      check("ill_done_err", {o_done, o_err}, 2'b11);
      check("ill_we", o_we, 0);
      check("ill_psr", o_psr, 5'b00000);
      check("ill_mem", mem[0], 16'h5555);

      // ADD R1, R2 must be accepted in the first IDLE cycle after WB
      run(16'h0152, 1'b0, 16'h0);
      check("b2b_waits", o_waits, 0);
      check("b2b_op", o_op, 8'h05);
      check("b2b_wb", {o_we, o_waddr, o_wdata, o_err}, {1'b1, 4'h1, 16'h0123, 1'b0});
      check("b2b_mem", mem[1], 16'h0123);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle execute sequencer that drives the 16-bit datapath ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes each one into the ALU's 8-bit opcode plus its A/B operands and carry-in.
- Reads operands from the external register file, writes the result back, and holds the 5-bit processor status register (PSR) built from the ALU flags.
- Sits between instruction fetch and the ALU/register file.

Parameters:
- DATA_W, 16, datapath width; the ALU is fixed at 16, so no other value is supported.
- RA_W, 4, register address width (16 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst  in  16  instruction word; sampled on handshake.
- inst_valid  in  1  inst is valid.
- inst_ready  out  1  sequencer can accept an instruction.
- rf_raddr_a  out  RA_W  register file read address for operand A (Rdest).
- rf_raddr_b  out  RA_W  register file read address for operand B (Rsrc).
- rf_rdata_a  in  16  read data A; synchronous, 1-cycle latency.
- rf_rdata_b  in  16  read data B; synchronous, 1-cycle latency.
- rf_we  out  1  write-back strobe.
- rf_waddr  out  RA_W  write-back address.
- rf_wdata  out  16  write-back data.
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_opcode  out  8  ALU opcode.
- alu_carry_in  out  1  ALU carry-in; equals psr[3].
- alu_c  in  16  ALU result (combinational).
- alu_flags  in  5  ALU flags: [4] Z, [3] C, [2] F, [1] L, [0] N.
- psr  out  5  processor status register.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse, coincident with done, for an illegal opcode.

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE. inst_ready=1. psr=0. rf_we, done, err = 0. All address, data and ALU outputs = 0.
- Instruction fields: hi=inst[15:12], Rdest=inst[11:8], ext=inst[7:4], lo=inst[3:0].
- Opcode decode:
  - hi=0000 or hi=1000: opcode = {hi, ext}.
  - All other hi: opcode = {hi, 4'b0000}.
- Legal opcodes: 00,01,02,03,04,05,06,07,08,09,0B,0C,0F,10,20,30,40,50,60,70,80–87,90,B0 (hex). Anything else is illegal.
- Operand B source:
  - Register: rf_rdata_b, for register-form ops (00–0B, 0F, 84–87).
  - 8-bit immediate {ext,lo}:
    - Sign-extended for 50, 70, 90, B0.
    - Zero-extended for 10, 20, 30, 40, 60.
  - 4-bit zero-extended lo: for 0C and 80–83.
- Operand A is always rf_rdata_a.
- FSM, one instruction per 4 cycles:
  - IDLE: inst_ready=1. On inst_valid=1, latch inst and go to READ. Hold in IDLE otherwise.
  - READ: inst_ready=0. Drive rf_raddr_a=Rdest and rf_raddr_b=lo. Go to EXEC.
  - EXEC: drive alu_a, alu_b, alu_opcode, alu_carry_in. Register alu_c and alu_flags on the clock edge. Go to WB.
  - WB: done=1. Write back and update PSR as below. Return to IDLE, where inst_ready=1 on the next cycle.
- Write-back rules in WB:
  - rf_we=1, rf_waddr=Rdest, rf_wdata=registered result for all legal opcodes except CMP family (08, 0B, 0C, B0) and NOP (00).
- PSR update rules in WB:
  - PSR is loaded from the registered flags for arithmetic, logic and compare ops.
  - PSR is unchanged for NOP and shifts (80–87).
- Illegal opcode:
  - No write, PSR unchanged. err=1 together with done in WB.
  - alu_opcode is driven 00 during EXEC.
- Carry: ADDC/ADDCU-family ops use the PSR carry as latched before the instruction. A carry produced in WB applies to the next instruction.
- alu_* outputs hold their last EXEC values in other states. Outputs are registered; no combinational path from inst to any output.

Test Plan:
- Reset mid-op: assert rst_n=0 during EXEC -> next cycle inst_ready=1, psr=0, no rf_we.
- ADDI: inst=5A FF (hex), R10=0x0005 -> alu_opcode=0x50, alu_b=0xFFFF, WB writes R10=0x0004, done pulse exactly 3 cycles after handshake.
- SUB to zero: inst=0x0391, R3=R1=0x1234 -> opcode 0x09, R3=0x0000, psr[4]=1.
- CMP signed: inst=0x02B3, R2=0x8000, R3=0x0001 -> opcode 0x0B, no rf_we, psr=5'b00011.
- ADDCU then shift: first set psr[3]=1 via ADDU 0xFFFF+0x0001. Then ADDCU R4=0,R5=0 gives R4=1 with alu_carry_in=1. Then LSHI inst=0x8403 (opcode 0x80, B=3) gives R4=0x0008 with psr unchanged.
- Illegal and back-to-back: inst=0xC000 -> err=1 with done, no write. Holding inst_valid=1 with the next instruction -> accepted in the IDLE cycle immediately after WB.
